// File: rtl/sme_feeder.sv
// Framing stage for the string-matching engine: buffers one string and one pattern
// from a byte stream, then replays them to the SME as a gap-free burst per job.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       err_ovf,
  output logic       err_seq,
  output logic [2:0] dbg_state
);
  localparam int SW = $clog2(STR_MAX) + 1;
  localparam int PW = $clog2(PAT_MAX) + 1;
  localparam int SA = $clog2(STR_MAX);
  localparam int PA = $clog2(PAT_MAX);

  // Handshake: a byte moves when in_valid & in_ready at the rising clock edge;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_STR, S_LOAD_PAT, S_SKIP, S_SEND_STR, S_SEND_PAT, S_WAIT
  } state_t;

  state_t        r_state;
  logic [7:0]    r_str_buf [STR_MAX];
  logic [7:0]    r_pat_buf [PAT_MAX];
  logic [SW-1:0] r_str_len;
  logic [PW-1:0] r_pat_len;
  logic [SW-1:0] r_rd_idx;
  logic          r_have_str;
  logic          r_str_pending;
  logic          r_ovf_seen;

  logic          w_xfer;
  logic          w_str_we;
  logic          w_pat_we;
  logic [SA-1:0] w_str_waddr;
  logic [PA-1:0] w_pat_waddr;
  logic [7:0]    w_pat0;
  logic          w_job_go;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD_STR) ||
                     (r_state == S_LOAD_PAT) || (r_state == S_SKIP);
  assign w_xfer    = in_valid & in_ready;
  assign dbg_state = r_state;

  // A one-byte pattern arrives in IDLE, so its byte is not yet in the buffer.
  assign w_pat0   = (r_state == S_IDLE) ? in_data : r_pat_buf[0];
  assign w_job_go = w_xfer & in_last &
                    (((r_state == S_IDLE) & in_kind & r_have_str) | (r_state == S_LOAD_PAT));

  always_comb begin
    w_str_we    = 1'b0;
    w_pat_we    = 1'b0;
    w_str_waddr = '0;
    w_pat_waddr = '0;
    if (w_xfer) begin
      if (r_state == S_IDLE) begin
        w_str_we = !in_kind;
        w_pat_we = in_kind & r_have_str;
      end else if (r_state == S_LOAD_STR && r_str_len != SW'(STR_MAX)) begin
        w_str_we    = 1'b1;
        w_str_waddr = r_str_len[SA-1:0];
      end else if (r_state == S_LOAD_PAT && r_pat_len != PW'(PAT_MAX)) begin
        w_pat_we    = 1'b1;
        w_pat_waddr = r_pat_len[PA-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_str_we) r_str_buf[w_str_waddr] <= in_data;
    if (w_pat_we) r_pat_buf[w_pat_waddr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_str_len     <= '0;
      r_pat_len     <= '0;
      r_rd_idx      <= '0;
      r_have_str    <= 1'b0;
      r_str_pending <= 1'b0;
      r_ovf_seen    <= 1'b0;
      chardata      <= '0;
      isstring      <= 1'b0;
      ispattern     <= 1'b0;
      err_ovf       <= 1'b0;
      err_seq       <= 1'b0;
    end else begin
      err_ovf <= 1'b0;
      err_seq <= 1'b0;
      case (r_state)
        S_IDLE: if (w_xfer) begin
          r_ovf_seen <= 1'b0;
          if (!in_kind) begin
            r_str_len <= SW'(1);
            if (in_last) begin
              r_have_str    <= 1'b1;
              r_str_pending <= 1'b1;
            end else begin
              r_state <= S_LOAD_STR;
            end
          end else if (r_have_str) begin
            r_pat_len <= PW'(1);
            if (!in_last) r_state <= S_LOAD_PAT;
          end else begin
            err_seq <= 1'b1;
            if (!in_last) r_state <= S_SKIP;
          end
        end
        S_LOAD_STR: if (w_xfer) begin
          if (r_str_len == SW'(STR_MAX)) begin
            err_ovf    <= !r_ovf_seen;
            r_ovf_seen <= 1'b1;
          end else begin
            r_str_len <= r_str_len + SW'(1);
          end
          if (in_last) begin
            r_have_str    <= 1'b1;
            r_str_pending <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_LOAD_PAT: if (w_xfer) begin
          if (r_pat_len == PW'(PAT_MAX)) begin
            err_ovf    <= !r_ovf_seen;
            r_ovf_seen <= 1'b1;
          end else begin
            r_pat_len <= r_pat_len + PW'(1);
          end
        end
        S_SKIP: if (w_xfer && in_last) r_state <= S_IDLE;
        S_SEND_STR: begin
          if (r_rd_idx < r_str_len) begin
            chardata <= r_str_buf[r_rd_idx[SA-1:0]];
            r_rd_idx <= r_rd_idx + SW'(1);
          end else begin
            chardata  <= r_pat_buf[0];
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            r_rd_idx  <= SW'(1);
            r_state   <= S_SEND_PAT;
          end
        end
        S_SEND_PAT: begin
          if (r_rd_idx < SW'(r_pat_len)) begin
            chardata <= r_pat_buf[r_rd_idx[PA-1:0]];
            r_rd_idx <= r_rd_idx + SW'(1);
          end else begin
            ispattern <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: if (sme_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // The first burst byte is registered on the same edge that accepts the last pattern byte.
      if (w_job_go) begin
        r_rd_idx <= SW'(1);
        if (r_str_pending) begin
          r_state       <= S_SEND_STR;
          chardata      <= r_str_buf[0];
          isstring      <= 1'b1;
          r_str_pending <= 1'b0;
        end else begin
          r_state   <= S_SEND_PAT;
          chardata  <= w_pat0;
          ispattern <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sme_feeder.sv
// Bench for sme_feeder: random items against a queue-based model of which bytes
// must appear on the SME side, plus literal checks on the documented examples.
module tb_sme_feeder;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       err_ovf;
  logic       err_seq;
  logic [2:0] dbg_state;

  sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_kind(in_kind), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .err_ovf(err_ovf), .err_seq(err_seq),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // scoreboard: {isstring, ispattern, chardata} expected on the SME side
  logic [9:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         run_q[$];
  logic [7:0] item_q[$];

  // model of the feeder's stored state
  logic [7:0] m_str[$];
  bit         m_have;
  bit         m_pend;
  logic [7:0] m_last_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every active output cycle must match the scoreboard head
  int run = 0;
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else if (isstring | ispattern) begin
      check("both_high", {31'd0, isstring & ispattern}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_out", {22'd0, isstring, ispattern, chardata}, 0);
      end else begin
        check("burst_byte", {22'd0, isstring, ispattern, chardata}, {22'd0, exp_q.pop_front()});
      end
      cap_q.push_back(chardata);
      run++;
    end else if (run > 0) begin
      run_q.push_back(run);
      run = 0;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input logic k, input logic last,
                           input int gap, input bit exp_ovf, input bit exp_seq);
    int t;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_kind  = k;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
    in_kind  = 1'($urandom);
    check("err_ovf", {31'd0, err_ovf}, {31'd0, exp_ovf});
    check("err_seq", {31'd0, err_seq}, {31'd0, exp_seq});
  endtask

  task automatic wait_job(input int exp_len);
    int t;
    int d;
    t = 0;
    while (run_q.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (run_q.size() == 0) check("burst_end_timeout", 0, 1);
    else check("burst_len", run_q.pop_front(), exp_len);
    check("exp_drained", exp_q.size(), 0);
    check("wait_isstring", {31'd0, isstring}, 0);
    check("wait_ispattern", {31'd0, ispattern}, 0);
    check("wait_chardata_hold", {24'd0, chardata}, {24'd0, m_last_byte});
    check("wait_in_ready", {31'd0, in_ready}, 0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(negedge clk);
      check("wait_in_ready_hold", {31'd0, in_ready}, 0);
    end
    sme_valid = 1'b1;
    @(negedge clk);
    sme_valid = 1'b0;
    check("ready_after_valid", {31'd0, in_ready}, 1);
  endtask

  // Send item_q as one item; kind 0 = string, 1 = pattern.
  task automatic send_item(input bit k, input int stall, input bit early, input bit abort);
    logic [7:0] b[$];
    int n, limit, gap, exp_len;
    bit job, seq;
    b = item_q;
    n = b.size();
    limit = k ? PAT_MAX : STR_MAX;
    job = k && m_have;
    seq = k && !m_have;
    exp_len = 0;
    for (int i = 0; i < n; i++) begin
      gap = (stall == 0) ? 0 : (stall == 1) ? 1 : $urandom_range(0, 2);
      if (i == n - 1 && job) begin
        if (m_pend) begin
          foreach (m_str[j]) exp_q.push_back({2'b10, m_str[j]});
          exp_len += m_str.size();
        end
        for (int j = 0; j < n && j < PAT_MAX; j++) begin
          exp_q.push_back({2'b01, b[j]});
          m_last_byte = b[j];
          exp_len++;
        end
        m_pend = 1'b0;
      end
      send_byte(b[i], (i == 0) ? k : 1'($urandom), (i == n - 1),
                gap, (n > limit) && (i == limit), seq && (i == 0));
    end
    if (!k) begin
      m_str.delete();
      for (int j = 0; j < n && j < STR_MAX; j++) m_str.push_back(b[j]);
      m_have = 1'b1;
      m_pend = 1'b1;
    end
    if (job) begin
      check("burst_start", {31'd0, isstring | ispattern}, 1);
      if (abort) begin
        #2 reset = 1'b1;
        #1;
        check("rst_isstring", {31'd0, isstring}, 0);
        check("rst_ispattern", {31'd0, ispattern}, 0);
        check("rst_chardata", {24'd0, chardata}, 0);
        exp_q.delete();
        m_str.delete();
        m_have = 1'b0;
        m_pend = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        run_q.delete();
        cap_q.delete();
      end else begin
        if (early) begin
          sme_valid = 1'b1;
          @(negedge clk);
          sme_valid = 1'b0;
        end
        wait_job(exp_len);
      end
    end
  endtask

  task automatic fill_random(input int n);
    item_q.delete();
    for (int i = 0; i < n; i++) item_q.push_back(8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s35[$];
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_kind = 1'b0; in_last = 1'b0; sme_valid = 1'b0;
    m_have = 1'b0; m_pend = 1'b0; m_last_byte = '0;
    repeat (2) @(negedge clk);
    check("reset_chardata", {24'd0, chardata}, 0);
    check("reset_isstring", {31'd0, isstring}, 0);
    check("reset_ispattern", {31'd0, ispattern}, 0);
    check("reset_err_ovf", {31'd0, err_ovf}, 0);
    check("reset_err_seq", {31'd0, err_seq}, 0);
    check("reset_in_ready", {31'd0, in_ready}, 1);
    reset = 1'b0;
    @(negedge clk);

    // pattern before any string: dropped with err_seq
    fill_random(3);
    send_item(1'b1, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("seq_ready", {31'd0, in_ready}, 1);

    // "ab c" then "b"
    item_q = '{8'h61, 8'h62, 8'h20, 8'h63};
    send_item(1'b0, 0, 1'b0, 1'b0);
    cap_q.delete();
    item_q = '{8'h62};
    send_item(1'b1, 0, 1'b0, 1'b0);
    check("lit1_size", cap_q.size(), 5);
    if (cap_q.size() == 5) begin
      check("lit1_b0", {24'd0, cap_q[0]}, 32'h61);
      check("lit1_b1", {24'd0, cap_q[1]}, 32'h62);
      check("lit1_b2", {24'd0, cap_q[2]}, 32'h20);
      check("lit1_b3", {24'd0, cap_q[3]}, 32'h63);
      check("lit1_b4", {24'd0, cap_q[4]}, 32'h62);
    end

    // "^a" with no string replay, sme_valid pulsed mid-burst and ignored
    cap_q.delete();
    item_q = '{8'h5E, 8'h61};
    send_item(1'b1, 0, 1'b1, 1'b0);
    check("lit2_size", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      check("lit2_b0", {24'd0, cap_q[0]}, 32'h5E);
      check("lit2_b1", {24'd0, cap_q[1]}, 32'h61);
    end

    // 32-byte string with upstream stalling every other cycle
    fill_random(32);
    send_item(1'b0, 1, 1'b0, 1'b0);
    cap_q.delete();
    fill_random(8);
    send_item(1'b1, 1, 1'b0, 1'b0);
    check("full_burst_size", cap_q.size(), 40);

    // 35-byte string and 10-byte pattern: both overflow once
    fill_random(35);
    s35 = item_q;
    send_item(1'b0, 2, 1'b0, 1'b0);
    cap_q.delete();
    fill_random(10);
    send_item(1'b1, 0, 1'b1, 1'b0);
    check("ovf_burst_size", cap_q.size(), 40);
    if (cap_q.size() == 40) check("ovf_last_str_byte", {24'd0, cap_q[31]}, {24'd0, s35[31]});

    // randomized items
    for (int it = 0; it < 40; it++) begin
      bit k;
      k = 1'($urandom);
      fill_random(k ? $urandom_range(1, 12) : $urandom_range(1, 40));
      send_item(k, $urandom_range(0, 2), 1'($urandom), 1'b0);
    end

    // reset in the middle of a burst discards everything
    fill_random(10);
    send_item(1'b0, 0, 1'b0, 1'b0);
    fill_random(3);
    send_item(1'b1, 0, 1'b0, 1'b1);
    fill_random(2);
    send_item(1'b1, 0, 1'b0, 1'b0);
    fill_random(5);
    send_item(1'b0, 0, 1'b0, 1'b0);
    fill_random(4);
    send_item(1'b1, 2, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
